shifter_serial: RTL

- Multi-cycle shift unit: the iterative, handshaked datapath counterpart to the combinational barrel shifter.
- Shifts a WIDTH-bit operand by one bit position per clock cycle and holds the result.
- Sits beside the ALU for low-area configurations.
- Accepts a shift request via start, reports busy while iterating and pulses done when result is valid.

---
 rtl/shifter_serial.sv | 97 +++++++++
 1 files changed

// File: rtl/shifter_serial.sv
// Iterative shifter: moves a WIDTH-bit operand one bit per clock, left or right (logical/arithmetic).
// Latency: done pulses shamt+1 cycles after the accepting start edge; result holds until next completion.
// Backpressure: start is ignored (not queued) while busy; a new request is accepted in the done cycle.
module shifter_serial #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               leftRight,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   sftSrc,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   data, data_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic               dir, dir_nxt;
  logic               ar, ar_nxt;
  logic [WIDTH-1:0]   result_nxt;
  logic               done_nxt;

  // The sign-fill bit is only ever the current MSB when arithmetic mode was captured.
  logic fill_bit;
  assign fill_bit = ar & data[WIDTH-1];

  // busy is decoded straight from the state so it drops on the same edge done rises.
  assign busy = (state == SHIFT);

  // Next-state and datapath: capture operands when idle, step one bit per cycle, publish at cnt==0.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data;
    cnt_nxt    = cnt;
    dir_nxt    = dir;
    ar_nxt     = ar;
    result_nxt = result;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          data_nxt  = sftSrc;
          cnt_nxt   = shamt;
          dir_nxt   = leftRight;
          ar_nxt    = arith;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - SHAMT_W'(1);
          if (dir) begin
            data_nxt = {data[WIDTH-2:0], 1'b0};
          end else begin
            data_nxt = {fill_bit, data[WIDTH-1:1]};
          end
        end else begin
          result_nxt = data;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight shift without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      ar     <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      data   <= data_nxt;
      cnt    <= cnt_nxt;
      dir    <= dir_nxt;
      ar     <= ar_nxt;
      result <= result_nxt;
      done   <= done_nxt;
    end
  end

endmodule
